// File: rtl/pkt_word_streamer.sv
// pkt_word_streamer
// Captures a whole packet image in a shadow register on pkt_load and plays it
// out MSB-word-first over a valid/ready handshake towards the packet parser.
// An optional idle gap follows every accepted non-final word. Start/end of
// packet are flagged alongside the data, and completed packets are counted.

module pkt_word_streamer #(
    parameter int DATA_W     = 32,
    parameter int PKT_WORDS  = 24,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W*PKT_WORDS-1:0]    pkt_in,
    input  logic                           pkt_load,
    output logic                           pkt_busy,
    output logic [DATA_W-1:0]              data_out,
    output logic                           valid_out,
    input  logic                           ready_in,
    output logic                           sof_out,
    output logic                           eof_out,
    output logic [$clog2(PKT_WORDS)-1:0]   word_idx,
    output logic                           pkt_done,
    output logic [CNT_W-1:0]               pkt_count
);

    localparam int                IDX_W    = $clog2(PKT_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PKT_WORDS - 1);
    // The gap counter counts down to zero, so it is loaded with one less than
    // the number of idle cycles wanted.
    localparam logic [3:0]        GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    // Shadow copy of the packet, one entry per word, entry 0 sent first.
    logic [DATA_W-1:0]  shadow_q [PKT_WORDS];
    logic [IDX_W-1:0]   idx_q;
    logic [3:0]         gap_q;
    logic               done_q;
    logic [CNT_W-1:0]   count_q;

    logic               load_ok;
    logic               xfer;
    logic               last_word;

    // A load is only honoured while idle; loads during a packet are dropped.
    assign load_ok   = (state_q == S_IDLE) && pkt_load;
    // valid_out is high exactly in SEND, so a transfer is SEND plus ready.
    assign xfer      = (state_q == S_SEND) && ready_in;
    assign last_word = (idx_q == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: IDLE -> SEND on load, SEND -> GAP/SEND/IDLE on a
    // transfer, GAP -> SEND once the programmed idle time has elapsed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pkt_load) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (ready_in) begin
                    if (last_word) begin
                        state_d = S_IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = S_SEND;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = S_SEND;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: everything presented to the parser follows from the
    // registered state and word index, so it cannot change while waiting.
    always_comb begin
        valid_out = (state_q == S_SEND);
        pkt_busy  = (state_q != S_IDLE);
        data_out  = valid_out ? shadow_q[idx_q] : '0;
        sof_out   = valid_out && (idx_q == '0);
        eof_out   = valid_out && last_word;
        word_idx  = idx_q;
        pkt_done  = done_q;
        pkt_count = count_q;
    end

    // Capture the packet image so pkt_in is free to change after the load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < PKT_WORDS; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (load_ok) begin
            for (int k = 0; k < PKT_WORDS; k++) begin
                shadow_q[k] <= pkt_in[DATA_W*(PKT_WORDS-k)-1 -: DATA_W];
            end
        end
    end

    // Word index: restarts on load, advances per transfer, wraps after the
    // final word so the block sits at word 0 while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
        end else if (load_ok) begin
            idx_q <= '0;
        end else if (xfer) begin
            idx_q <= last_word ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Gap counter: armed by a non-final transfer, counts down in GAP only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_q <= 4'd0;
        end else if (xfer && !last_word) begin
            gap_q <= GAP_LOAD;
        end else if ((state_q == S_GAP) && (gap_q != 4'd0)) begin
            gap_q <= gap_q - 4'd1;
        end
    end

    // Completion: one-cycle done pulse and wrapping packet counter, both
    // driven by the handshake of the final word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            done_q <= xfer && last_word;
            if (xfer && last_word) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule
